// File: rtl/voice_allocator.sv
// voice_allocator
//   Assigns incoming MIDI note events to the synth's voice pipelines.
//   A note-on retriggers a voice already sounding that note. Otherwise it
//   takes the lowest free voice, then the oldest releasing voice, and as a
//   last resort it steals the oldest held voice. A note-off releases the
//   lowest held voice playing that note. A voice returns to the free pool
//   when its envelope reports that the release has finished.
//
// Parameters
//   VOICES       number of voice pipelines (power of two, >= 2)
//   NOTE_WIDTH   MIDI note number width
//   VEL_WIDTH    velocity width
//
// Ports
//   clock           system clock
//   reset_l         synchronous active-low reset
//   ev_valid        event present
//   ev_ready        allocator can accept an event (registered)
//   ev_on           1 = note-on, 0 = note-off (velocity 0 also means note-off)
//   ev_note         note number
//   ev_velocity     velocity
//   voice_done      per-voice pulse: envelope release finished
//   voice_gate      per-voice key held
//   voice_trigger   per-voice one-cycle start/restart pulse
//   voice_note      per-voice note, slice i = [i*NOTE_WIDTH +: NOTE_WIDTH]
//   voice_velocity  per-voice velocity, packed like voice_note
//   voice_busy      per-voice not idle
//   steal           one-cycle pulse when a held voice is stolen
module voice_allocator #(
    parameter int VOICES     = 4,
    parameter int NOTE_WIDTH = 7,
    parameter int VEL_WIDTH  = 7
) (
    input  logic                           clock,
    input  logic                           reset_l,
    input  logic                           ev_valid,
    output logic                           ev_ready,
    input  logic                           ev_on,
    input  logic [NOTE_WIDTH-1:0]          ev_note,
    input  logic [VEL_WIDTH-1:0]           ev_velocity,
    input  logic [VOICES-1:0]              voice_done,
    output logic [VOICES-1:0]              voice_gate,
    output logic [VOICES-1:0]              voice_trigger,
    output logic [VOICES*NOTE_WIDTH-1:0]   voice_note,
    output logic [VOICES*VEL_WIDTH-1:0]    voice_velocity,
    output logic [VOICES-1:0]              voice_busy,
    output logic                           steal
);

    localparam int RANK_W = $clog2(VOICES);

    typedef enum logic {
        S_ACCEPT,
        S_APPLY
    } fsm_t;

    typedef enum logic [1:0] {
        V_IDLE,
        V_HELD,
        V_RELEASE
    } vstate_t;

    fsm_t                  fsm;
    logic                  ready_q;
    vstate_t               vstate  [VOICES];
    logic [RANK_W-1:0]     rank    [VOICES];
    logic [NOTE_WIDTH-1:0] note_r  [VOICES];
    logic [VEL_WIDTH-1:0]  vel_r   [VOICES];
    logic [VOICES-1:0]     trig_r;
    logic                  steal_r;

    // Event captured at the accept edge, with the target already chosen.
    logic                  on_q;
    logic                  hit_q;
    logic                  steal_q;
    logic [RANK_W-1:0]     tgt_q;
    logic [NOTE_WIDTH-1:0] note_q;
    logic [VEL_WIDTH-1:0]  vel_q;

    // Combinational search over the currently registered voice state.
    logic                  is_on;
    logic                  s_hit;
    logic                  s_steal;
    logic [RANK_W-1:0]     s_tgt;

    logic                  m_hit, o_hit, i_hit, r_hit, h_hit;
    logic [RANK_W-1:0]     m_idx, o_idx, i_idx, r_idx, h_idx;
    logic [RANK_W-1:0]     r_rank, h_rank;

    always_comb begin
        is_on   = ev_on && (ev_velocity != '0);
        m_hit   = 1'b0;  m_idx  = '0;
        o_hit   = 1'b0;  o_idx  = '0;
        i_hit   = 1'b0;  i_idx  = '0;
        r_hit   = 1'b0;  r_idx  = '0;  r_rank = '0;
        h_hit   = 1'b0;  h_idx  = '0;  h_rank = '0;
        s_hit   = 1'b0;
        s_steal = 1'b0;
        s_tgt   = '0;

        for (int unsigned i = 0; i < VOICES; i++) begin
            // Ascending scan with first-hit latching gives lowest-index priority.
            if (!m_hit && vstate[i] != V_IDLE && note_r[i] == ev_note) begin
                m_hit = 1'b1;
                m_idx = RANK_W'(i);
            end
            if (!o_hit && vstate[i] == V_HELD && note_r[i] == ev_note) begin
                o_hit = 1'b1;
                o_idx = RANK_W'(i);
            end
            if (!i_hit && vstate[i] == V_IDLE) begin
                i_hit = 1'b1;
                i_idx = RANK_W'(i);
            end
            // Ranks are a permutation, so the oldest candidate is unique.
            if (vstate[i] == V_RELEASE && (!r_hit || rank[i] > r_rank)) begin
                r_hit  = 1'b1;
                r_idx  = RANK_W'(i);
                r_rank = rank[i];
            end
            if (vstate[i] == V_HELD && (!h_hit || rank[i] > h_rank)) begin
                h_hit  = 1'b1;
                h_idx  = RANK_W'(i);
                h_rank = rank[i];
            end
        end

        if (is_on) begin
            s_hit = 1'b1;
            if (m_hit) begin
                s_tgt = m_idx;
            end else if (i_hit) begin
                s_tgt = i_idx;
            end else if (r_hit) begin
                s_tgt = r_idx;
            end else begin
                s_tgt   = h_idx;
                s_steal = 1'b1;
            end
        end else begin
            s_hit = o_hit;
            s_tgt = o_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_l) begin
            fsm     <= S_ACCEPT;
            ready_q <= 1'b0;
            trig_r  <= '0;
            steal_r <= 1'b0;
            on_q    <= 1'b0;
            hit_q   <= 1'b0;
            steal_q <= 1'b0;
            tgt_q   <= '0;
            note_q  <= '0;
            vel_q   <= '0;
            for (int unsigned i = 0; i < VOICES; i++) begin
                vstate[i] <= V_IDLE;
                rank[i]   <= RANK_W'(i);
                note_r[i] <= '0;
                vel_r[i]  <= '0;
            end
        end else begin
            trig_r  <= '0;
            steal_r <= 1'b0;

            // Release completion. The apply below is written later in this
            // block, so on a collision its assignment to the target wins.
            for (int unsigned i = 0; i < VOICES; i++) begin
                if (voice_done[i] && vstate[i] == V_RELEASE) begin
                    vstate[i] <= V_IDLE;
                end
            end

            case (fsm)
                S_ACCEPT: begin
                    if (ev_valid && ready_q) begin
                        on_q    <= is_on;
                        hit_q   <= s_hit;
                        steal_q <= s_steal;
                        tgt_q   <= s_tgt;
                        note_q  <= ev_note;
                        vel_q   <= ev_velocity;
                        ready_q <= 1'b0;
                        fsm     <= S_APPLY;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_APPLY: begin
                    if (hit_q) begin
                        if (on_q) begin
                            vstate[tgt_q] <= V_HELD;
                            note_r[tgt_q] <= note_q;
                            vel_r[tgt_q]  <= vel_q;
                            trig_r[tgt_q] <= 1'b1;
                            steal_r       <= steal_q;
                            for (int unsigned i = 0; i < VOICES; i++) begin
                                if (RANK_W'(i) == tgt_q) begin
                                    rank[i] <= '0;
                                end else if (rank[i] < rank[tgt_q]) begin
                                    rank[i] <= rank[i] + RANK_W'(1);
                                end
                            end
                        end else begin
                            vstate[tgt_q] <= V_RELEASE;
                        end
                    end
                    ready_q <= 1'b1;
                    fsm     <= S_ACCEPT;
                end
                default: begin
                    ready_q <= 1'b0;
                    fsm     <= S_ACCEPT;
                end
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < VOICES; i++) begin
            voice_gate[i]                             = (vstate[i] == V_HELD);
            voice_busy[i]                             = (vstate[i] != V_IDLE);
            voice_note[i*NOTE_WIDTH +: NOTE_WIDTH]    = note_r[i];
            voice_velocity[i*VEL_WIDTH +: VEL_WIDTH]  = vel_r[i];
        end
    end

    assign ev_ready      = ready_q;
    assign voice_trigger = trig_r;
    assign steal         = steal_r;

endmodule

// File: tb/tb_voice_allocator.sv
// Testbench for voice_allocator: directed scenarios followed by random
// events, all checked against a behavioural model that keeps voice age as
// an ordered list (newest first).
module tb_voice_allocator;

    localparam int V  = 4;
    localparam int NW = 7;
    localparam int VW = 7;

    localparam int IDLE = 0;
    localparam int HELD = 1;
    localparam int REL  = 2;

    logic              clock = 1'b0;
    logic              reset_l;
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_on;
    logic [NW-1:0]     ev_note;
    logic [VW-1:0]     ev_velocity;
    logic [V-1:0]      voice_done;
    logic [V-1:0]      voice_gate;
    logic [V-1:0]      voice_trigger;
    logic [V*NW-1:0]   voice_note;
    logic [V*VW-1:0]   voice_velocity;
    logic [V-1:0]      voice_busy;
    logic              steal;

    always #5 clock = ~clock;

    voice_allocator #(
        .VOICES(V),
        .NOTE_WIDTH(NW),
        .VEL_WIDTH(VW)
    ) dut (
        .clock(clock),
        .reset_l(reset_l),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_on(ev_on),
        .ev_note(ev_note),
        .ev_velocity(ev_velocity),
        .voice_done(voice_done),
        .voice_gate(voice_gate),
        .voice_trigger(voice_trigger),
        .voice_note(voice_note),
        .voice_velocity(voice_velocity),
        .voice_busy(voice_busy),
        .steal(steal)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model
    int        m_st   [V];
    int        m_note [V];
    int        m_vel  [V];
    int        order  [$];   // voice indices, newest first
    logic [V-1:0] exp_trig;
    logic         exp_steal;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void model_reset();
        order = {};
        for (int i = 0; i < V; i++) begin
            m_st[i]   = IDLE;
            m_note[i] = 0;
            m_vel[i]  = 0;
            order.push_back(i);
        end
        exp_trig  = '0;
        exp_steal = 1'b0;
    endfunction

    // Target voice for an event, or -1 when a note-off finds nothing.
    function automatic int pick(input bit on, input int note, output bit stl);
        stl = 1'b0;
        if (on) begin
            for (int i = 0; i < V; i++)
                if (m_st[i] != IDLE && m_note[i] == note) return i;
            for (int i = 0; i < V; i++)
                if (m_st[i] == IDLE) return i;
            for (int k = order.size() - 1; k >= 0; k--)
                if (m_st[order[k]] == REL) return order[k];
            stl = 1'b1;
            return order[order.size() - 1];
        end
        for (int i = 0; i < V; i++)
            if (m_st[i] == HELD && m_note[i] == note) return i;
        return -1;
    endfunction

    task automatic check_outputs(input string tag);
        logic [V-1:0]    eg;
        logic [V-1:0]    eb;
        logic [V*NW-1:0] en;
        logic [V*VW-1:0] ev;
        for (int i = 0; i < V; i++) begin
            eg[i]             = (m_st[i] == HELD);
            eb[i]             = (m_st[i] != IDLE);
            en[i*NW +: NW]    = NW'(m_note[i]);
            ev[i*VW +: VW]    = VW'(m_vel[i]);
        end
        check({tag, ".gate"},    voice_gate,     eg);
        check({tag, ".busy"},    voice_busy,     eb);
        check({tag, ".note"},    voice_note,     en);
        check({tag, ".vel"},     voice_velocity, ev);
        check({tag, ".trigger"}, voice_trigger,  exp_trig);
        check({tag, ".steal"},   steal,          exp_steal);
    endtask

    task automatic do_reset();
        reset_l     = 1'b0;
        ev_valid    = 1'b0;
        ev_on       = 1'b0;
        ev_note     = '0;
        ev_velocity = '0;
        voice_done  = '0;
        tick();
        tick();
        model_reset();
        check("rst.ready_low", ev_ready, 1'b0);
        check_outputs("rst");
        reset_l = 1'b1;
        tick();
        check("rst.ready_after", ev_ready, 1'b1);
    endtask

    // One event; dmask is driven as voice_done during the apply cycle.
    task automatic send(input bit on, input int note, input int vel, input logic [V-1:0] dmask);
        int  waited = 0;
        bit  eff_on;
        bit  stl;
        int  tgt;
        int  pos;
        while (ev_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (ev_ready !== 1'b1) begin
            check("ready_timeout", ev_ready, 1'b1);
            return;
        end
        ev_valid    = 1'b1;
        ev_on       = on;
        ev_note     = NW'(note);
        ev_velocity = VW'(vel);
        tick();
        ev_valid   = 1'b0;
        voice_done = dmask;
        check("accept.ready_low", ev_ready, 1'b0);
        check("accept.trig_clear", voice_trigger, '0);
        check("accept.steal_clear", steal, 1'b0);

        eff_on = on && (vel != 0);
        tgt    = pick(eff_on, note, stl);
        tick();
        voice_done = '0;

        for (int i = 0; i < V; i++)
            if (dmask[i] && i != tgt && m_st[i] == REL) m_st[i] = IDLE;
        exp_trig  = '0;
        exp_steal = 1'b0;
        if (tgt >= 0) begin
            if (eff_on) begin
                m_st[tgt]   = HELD;
                m_note[tgt] = note;
                m_vel[tgt]  = vel;
                exp_trig[tgt] = 1'b1;
                exp_steal   = stl;
                pos = 0;
                for (int k = 0; k < order.size(); k++)
                    if (order[k] == tgt) pos = k;
                order.delete(pos);
                order.push_front(tgt);
            end else begin
                m_st[tgt] = REL;
            end
        end
        check_outputs("apply");
        check("apply.ready_back", ev_ready, 1'b1);
    endtask

    task automatic pulse_done(input logic [V-1:0] mask);
        voice_done = mask;
        tick();
        voice_done = '0;
        for (int i = 0; i < V; i++)
            if (mask[i] && m_st[i] == REL) m_st[i] = IDLE;
        exp_trig  = '0;
        exp_steal = 1'b0;
        check_outputs("done");
    endtask

    initial begin
        do_reset();

        // Fill in order, then steal the oldest.
        send(1, 60, 100, '0);
        send(1, 62, 100, '0);
        send(1, 64, 100, '0);
        send(1, 65, 100, '0);
        check("fill.busy", voice_busy, 4'b1111);
        send(1, 67, 100, '0);
        check("steal.trigger", voice_trigger, 4'b0001);
        check("steal.pulse", steal, 1'b1);

        // Releasing voice preferred over a steal.
        send(0, 64, 0, '0);
        check("off64.gate", voice_gate, 4'b1011);
        send(1, 69, 100, '0);
        check("rel_pref.trigger", voice_trigger, 4'b0100);
        check("rel_pref.steal", steal, 1'b0);

        // Retrigger of a releasing voice on the same note.
        do_reset();
        send(1, 60, 100, '0);
        send(0, 60, 0, '0);
        send(1, 60, 55, '0);
        check("retrig.trigger", voice_trigger, 4'b0001);
        check("retrig.vel", voice_velocity[VW-1:0], 7'd55);

        // Release completion, then done colliding with an apply.
        send(1, 62, 90, '0);
        send(0, 62, 0, '0);
        pulse_done(4'b0010);
        check("done.busy", voice_busy, 4'b0001);
        send(0, 60, 0, '0);
        send(1, 60, 77, 4'b0001);
        check("collide.gate", voice_gate, 4'b0001);

        // Velocity 0 acts as note-off; unheld note-off is a no-op.
        send(1, 60, 0, '0);
        check("vel0.gate", voice_gate, 4'b0000);
        send(0, 99, 0, '0);

        // Reset landing on the apply edge drops the event.
        tick();
        ev_valid    = 1'b1;
        ev_on       = 1'b1;
        ev_note     = 7'd70;
        ev_velocity = 7'd90;
        tick();
        ev_valid = 1'b0;
        reset_l  = 1'b0;
        tick();
        model_reset();
        check_outputs("rst_apply");
        check("rst_apply.ready", ev_ready, 1'b0);
        reset_l = 1'b1;
        tick();
        check("rst_apply.ready_after", ev_ready, 1'b1);

        // Random traffic over a small note range to force collisions.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                send(($urandom % 4) != 0,
                     60 + int'($urandom % 6),
                     (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 127)),
                     (($urandom % 3) == 0) ? V'($urandom) : '0);
            end else begin
                pulse_done(V'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Schedules the synth's `PIPELINE_COUNT` voice pipelines among incoming MIDI note events. It sits between the MIDI byte decoder and the voice pipelines. For each event it picks a target voice:
- retrigger a voice already holding the note,
- else use a free voice,
- else steal the least-recently-triggered voice.

It then drives that voice's note, velocity, gate and trigger. Voices return to the free pool when their envelope reports release complete.

## Interface
- `VOICES`, default `CONFIG::PIPELINE_COUNT` (4): number of voice pipelines; power of two, ≥2.
- `NOTE_WIDTH`, default 7: MIDI note number width.
- `VEL_WIDTH`, default `CONFIG::PERCENT_WIDTH` (7): velocity width.
- `clock` in 1: system clock, `CONFIG::SYSTEM_CLOCK`. One clock only.
- `reset_l` in 1: synchronous, active-low reset.
- `ev_valid` in 1: event present.
- `ev_ready` out 1: allocator can accept an event.
- `ev_on` in 1: 1 = note-on, 0 = note-off.
- `ev_note` in `NOTE_WIDTH`: note number.
- `ev_velocity` in `VEL_WIDTH`: velocity. A note-on with velocity 0 is treated as note-off.
- `voice_done` in `VOICES`: per-voice one-cycle pulse meaning the envelope release has finished.
- `voice_gate` out `VOICES`: high while the voice's key is held.
- `voice_trigger` out `VOICES`: one-cycle pulse when a voice starts or restarts.
- `voice_note` out `VOICES*NOTE_WIDTH`: per-voice note; slice i is bits `[i*NOTE_WIDTH +: NOTE_WIDTH]`.
- `voice_velocity` out `VOICES*VEL_WIDTH`: per-voice velocity, packed the same way.
- `voice_busy` out `VOICES`: voice is not IDLE.
- `steal` out 1: one-cycle pulse when a HELD voice is stolen.

## Operation
- **Voice state.** Each voice is in IDLE, HELD or RELEASE.
- **Rank.** Each voice has an LRU rank, `$clog2(VOICES)` bits: 0 = newest, `VOICES-1` = oldest. Ranks are always a permutation of 0..VOICES-1.
- **Control FSM.**
  - ACCEPT: `ev_ready=1`. On `ev_valid&ev_ready`, register the event and the search result, then go to APPLY.
  - APPLY: `ev_ready=0`. Write the voice state, then return to ACCEPT.
- **Note-on target, in priority order:**
  1. A HELD or RELEASE voice with a matching note; lowest index if several match.
  2. The lowest-index IDLE voice.
  3. The RELEASE voice with the highest rank.
  4. The HELD voice with the highest rank; assert `steal`.
- **Note-on apply to target v:**
  - state ← HELD; load note and velocity; gate ← 1; pulse `voice_trigger[v]`.
  - Rank update: if v's old rank is r, every voice with rank < r gets +1, and v gets 0.
- **Note-off:** the lowest-index HELD voice with a matching note goes to RELEASE and its gate drops to 0. Rank, note and velocity are unchanged. If no HELD voice matches, the event is consumed with no effect.
- **voice_done[i]:**
  - In RELEASE: the voice goes to IDLE.
  - In HELD or IDLE: ignored.
  - IDLE voices keep their last note and velocity on the outputs.
- **Search snapshot.** The search uses voice state as registered at the accept edge. A `voice_done` arriving between the accept edge and the APPLY edge still frees its voice, but does not change the target already chosen.
- **Done vs. apply collision.** A `voice_done[v]` in the same cycle as APPLY targeting voice v is discarded; the applied event wins. A done for any other voice is applied normally.

## Timing
- Reset, for one or more cycles with `reset_l=0` at the edge:
  - FSM → ACCEPT; all voices IDLE; rank[i]=i.
  - Note and velocity registers → 0.
  - `voice_gate`, `voice_trigger`, `voice_busy`, `steal` → 0.
  - `ev_ready=0` while `reset_l` is low; `ev_ready=1` from the first cycle after release.
- If reset asserts during APPLY, the pending event is dropped.
- Event accepted at edge k:
  - `ev_ready` is 0 in cycle k..k+1.
  - At edge k+1 the voice registers update.
  - `voice_gate`, `voice_busy` and the note/velocity outputs show the new values from edge k+1.
  - `voice_trigger` and `steal` are high for exactly the cycle after edge k+1.
  - `ev_ready` returns to 1 after edge k+1.
  - Maximum throughput is one event per 2 cycles.
- `voice_done` at edge j: `voice_busy` drops after edge j, i.e. 1 cycle of latency.
- All outputs are registered. No combinational path from inputs to outputs except `ev_ready`, which depends only on the FSM state.

## Test plan
- **Fill in order.** After reset, send note-ons 60, 62, 64, 65 (velocity 100), each 2 cycles apart. Required:
  - voices 0..3 trigger in order with those notes;
  - `voice_busy=4'b1111`;
  - final ranks {3,2,1,0};
  - `steal` never pulses.
- **Steal.** With all voices HELD as above, send note-on 67. Required:
  - voice 0 (oldest) retriggers with note 67;
  - `steal` pulses once;
  - voice 0 ends with rank 0 and all other ranks increment.
- **Prefer RELEASE over steal.** From the full state, note-off 64, then note-on 69. Required:
  - voice 2 gate drops, then voice 2 retriggers with note 69, gate 1;
  - `steal=0`.
- **Retrigger same note.** Note-on 60 while voice 0 is in RELEASE on note 60. Required:
  - voice 0 returns to HELD, triggers, velocity is reloaded;
  - no other voice changes.
- **Done and collision.**
  - Voice 1 in RELEASE with `voice_done[1]` pulsed: `voice_busy[1]` drops 1 cycle later.
  - `voice_done[v]` coincident with the APPLY edge of a note-on targeting v: v stays HELD.
- **Edge cases.**
  - Note-on with velocity 0 for a held note: behaves as a note-off.
  - Note-off for an unheld note: no state change, `ev_ready` returns to 1.
  - `reset_l` low during APPLY: all IDLE, no trigger.
